// File: rtl/ani_pkg.sv
// Shared widths, FSM state type and index-step helper for the animation sequencer.
package ani_pkg;

  localparam int ANI_W   = 4;
  localparam int FRAME_W = 5;
  localparam int SPEED_W = 5;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_PAUSE = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  // Modulo-num step of the animation index, forward or backward.
  function automatic logic [ANI_W-1:0] ani_step(input logic [ANI_W-1:0] idx,
                                                input logic             fwd,
                                                input int               num);
    if (fwd) return (idx == ANI_W'(num - 1)) ? '0 : idx + 1'b1;
    else     return (idx == '0) ? ANI_W'(num - 1) : idx - 1'b1;
  endfunction

endpackage

// File: rtl/ani_prescaler.sv
// Two-level frame prescaler: sub counts base ticks, unit counts speed units.
module ani_prescaler
  import ani_pkg::*;
#(
  parameter int BASE_TICKS = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [SPEED_W-1:0] speed,
  output logic               tick
);

  localparam int SUB_W = (BASE_TICKS > 1) ? $clog2(BASE_TICKS) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BASE_TICKS - 1);

  logic [SUB_W-1:0]   r_sub;
  logic [SPEED_W-1:0] r_unit;
  logic               w_sub_wrap;
  logic               w_term;

  assign w_sub_wrap = (r_sub == SUB_LAST);
  assign w_term     = w_sub_wrap && (r_unit == (speed - SPEED_W'(1)));
  // A clear in the same cycle swallows the tick so the frame holds.
  assign tick       = en && !clr && w_term;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_sub  <= '0;
      r_unit <= '0;
    end else if (en) begin
      if (w_term) begin
        r_sub  <= '0;
        r_unit <= '0;
      end else if (w_sub_wrap) begin
        r_sub  <= '0;
        r_unit <= r_unit + 1'b1;
      end else begin
        r_sub  <= r_sub + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ani_sequencer.sv
// Playback controller: animation index, frame counter, speed and PLAY/PAUSE/BLANK FSM.
// Define ANI_SEQ_AUTO_CYCLE_EN to auto-advance after AUTO_LOOPS completed loops.
module ani_sequencer
  import ani_pkg::*;
#(
  parameter int NUM_ANI       = 12,
  parameter int BASE_TICKS    = 1_000_000,
  parameter int SPEED_DEFAULT = 10,
  parameter int SPEED_MIN     = 1,
  parameter int SPEED_MAX     = 19,
  parameter int BLANK_CYCLES  = 100_000,
  parameter int AUTO_LOOPS    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               next_pls,
  input  logic               prev_pls,
  input  logic               faster_pls,
  input  logic               slower_pls,
  input  logic               pause_pls,
  input  logic [FRAME_W-1:0] frame_limit,
  output logic [ANI_W-1:0]   animation,
  output logic [FRAME_W-1:0] frame,
  output logic [SPEED_W-1:0] speed,
  output logic               blank,
  output logic               paused,
  output logic               frame_tick
);

  localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BLANK_W-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? BLANK_W'(BLANK_CYCLES - 1) : '0;

  state_e             r_state;
  state_e             w_state_next;
  logic [ANI_W-1:0]   r_animation;
  logic [FRAME_W-1:0] r_frame;
  logic [SPEED_W-1:0] r_speed;
  logic               r_frame_tick;
  logic [BLANK_W-1:0] r_blank_cnt;

  logic w_next_evt;
  logic w_ani_chg;
  logic w_faster_ok;
  logic w_slower_ok;
  logic w_speed_chg;
  logic w_presc_en;
  logic w_presc_clr;
  logic w_tick;

`ifdef ANI_SEQ_AUTO_CYCLE_EN
  localparam int LOOP_W = (AUTO_LOOPS > 0) ? $clog2(AUTO_LOOPS + 1) : 1;
  logic [LOOP_W-1:0] r_loops;
  logic              w_wrap;

  // w_tick only fires in PLAY, so the count naturally holds through PAUSE.
  assign w_wrap = w_tick && (r_frame >= frame_limit);

  always_ff @(posedge clk) begin
    if (reset || w_ani_chg) r_loops <= '0;
    else if (w_wrap)        r_loops <= r_loops + 1'b1;
  end

  assign w_next_evt = next_pls || (r_loops == LOOP_W'(AUTO_LOOPS));
`else
  assign w_next_evt = next_pls;
`endif

  assign w_ani_chg   = w_next_evt || prev_pls;
  assign w_faster_ok = faster_pls && (r_speed > SPEED_W'(SPEED_MIN));
  assign w_slower_ok = !faster_pls && slower_pls && (r_speed < SPEED_W'(SPEED_MAX));
  assign w_speed_chg = w_faster_ok || w_slower_ok;
  assign w_presc_en  = (r_state == ST_PLAY);
  assign w_presc_clr = w_ani_chg || w_speed_chg || (r_state == ST_BLANK);

  ani_prescaler #(
    .BASE_TICKS(BASE_TICKS)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (w_presc_en),
    .clr  (w_presc_clr),
    .speed(r_speed),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_PLAY;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_ani_chg) begin
      w_state_next = (BLANK_CYCLES > 0) ? ST_BLANK : ST_PLAY;
    end else begin
      case (r_state)
        ST_PLAY:  if (pause_pls) w_state_next = ST_PAUSE;
        ST_PAUSE: if (pause_pls) w_state_next = ST_PLAY;
        ST_BLANK: if (r_blank_cnt == '0) w_state_next = ST_PLAY;
        default:  w_state_next = ST_PLAY;
      endcase
    end
  end

  always_comb begin
    blank      = (r_state == ST_BLANK);
    paused     = (r_state == ST_PAUSE);
    animation  = r_animation;
    frame      = r_frame;
    speed      = r_speed;
    frame_tick = r_frame_tick;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_animation  <= '0;
      r_frame      <= '0;
      r_speed      <= SPEED_W'(SPEED_DEFAULT);
      r_frame_tick <= 1'b0;
      r_blank_cnt  <= '0;
    end else begin
      r_frame_tick <= w_tick;
      if (w_ani_chg) begin
        r_animation <= ani_step(r_animation, w_next_evt, NUM_ANI);
        r_frame     <= '0;
        r_blank_cnt <= BLANK_LOAD;
      end else begin
        // A frame past a freshly lowered limit also wraps here.
        if (w_tick) r_frame <= (r_frame >= frame_limit) ? '0 : r_frame + 1'b1;
        if (r_state == ST_BLANK && r_blank_cnt != '0) r_blank_cnt <= r_blank_cnt - 1'b1;
      end
      if (w_faster_ok)      r_speed <= r_speed - 1'b1;
      else if (w_slower_ok) r_speed <= r_speed + 1'b1;
    end
  end

endmodule

// File: tb/tb_ani_sequencer.sv
// Directed self-checking bench for ani_sequencer (small BASE_TICKS/BLANK_CYCLES).
module tb_ani_sequencer;
  import ani_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               next_pls = 1'b0;
  logic               prev_pls = 1'b0;
  logic               faster_pls = 1'b0;
  logic               slower_pls = 1'b0;
  logic               pause_pls = 1'b0;
  logic [FRAME_W-1:0] frame_limit = 5'd3;
  logic [ANI_W-1:0]   animation;
  logic [FRAME_W-1:0] frame;
  logic [SPEED_W-1:0] speed;
  logic               blank;
  logic               paused;
  logic               frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  ani_sequencer #(
    .NUM_ANI      (12),
    .BASE_TICKS   (4),
    .SPEED_DEFAULT(2),
    .SPEED_MIN    (1),
    .SPEED_MAX    (19),
    .BLANK_CYCLES (3),
    .AUTO_LOOPS   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .next_pls   (next_pls),
    .prev_pls   (prev_pls),
    .faster_pls (faster_pls),
    .slower_pls (slower_pls),
    .pause_pls  (pause_pls),
    .frame_limit(frame_limit),
    .animation  (animation),
    .frame      (frame),
    .speed      (speed),
    .blank      (blank),
    .paused     (paused),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Counts negedges until frame_tick is seen; n exceeds budget on timeout.
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n <= budget);
  endtask

  // Counts consecutive blank-high samples, ending on the first low one.
  task automatic count_blank(output int bc);
    bc = 0;
    while (blank && bc < 20) begin
      bc++;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ani"},   int'(animation), 0);
    check_eq({tag, "_frame"}, int'(frame), 0);
    check_eq({tag, "_speed"}, int'(speed), 2);
    check_eq({tag, "_blank"}, int'(blank), 0);
    check_eq({tag, "_pause"}, int'(paused), 0);
    check_eq({tag, "_tick"},  int'(frame_tick), 0);
  endtask

  initial begin
    int n;
    int bc;
    int ticks_seen;
    int exp_frames[5] = '{1, 2, 3, 0, 1};

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;

`ifdef ANI_SEQ_AUTO_CYCLE_EN
    for (int i = 0; i < 8; i++) begin
      wait_tick(20, n);
      check_eq("auto_period", n, 8);
    end
    check_eq("auto_wrap_frame", int'(frame), 0);
    check_eq("auto_wrap_ani", int'(animation), 0);
    @(negedge clk);
    check_eq("auto_adv_ani", int'(animation), 1);
    count_blank(bc);
    check_eq("auto_blank_len", bc, 3);
`else
    // Free run: period 8, frames wrap at limit 3.
    for (int i = 0; i < 5; i++) begin
      wait_tick(20, n);
      check_eq("run_period", n, 8);
      check_eq("run_frame", int'(frame), exp_frames[i]);
    end
    @(negedge clk);
    check_eq("tick_one_cycle", int'(frame_tick), 0);
    wait_tick(20, n);
    check_eq("pre_lower_frame", int'(frame), 2);
    frame_limit = 5'd1;
    wait_tick(20, n);
    check_eq("lowered_limit_wrap", int'(frame), 0);
    frame_limit = 5'd3;

    // prev from index 0 wraps to 11 and blanks for 3 cycles.
    prev_pls = 1'b1;
    @(negedge clk);
    prev_pls = 1'b0;
    check_eq("prev_wrap_ani", int'(animation), 11);
    check_eq("prev_frame0", int'(frame), 0);
    count_blank(bc);
    check_eq("prev_blank_len", bc, 3);
    wait_tick(20, n);
    check_eq("tick_after_blank", n, 8);
    check_eq("frame_after_blank", int'(frame), 1);

    // Speed saturation and resulting tick period.
    faster_pls = 1'b1;
    repeat (12) @(negedge clk);
    faster_pls = 1'b0;
    check_eq("speed_min_sat", int'(speed), 1);
    wait_tick(100, n);
    wait_tick(100, n);
    check_eq("period_fast", n, 4);
    slower_pls = 1'b1;
    repeat (20) @(negedge clk);
    slower_pls = 1'b0;
    check_eq("speed_max_sat", int'(speed), 19);
    wait_tick(200, n);
    wait_tick(200, n);
    check_eq("period_slow", n, 76);
    faster_pls = 1'b1;
    repeat (17) @(negedge clk);
    faster_pls = 1'b0;
    check_eq("speed_restored", int'(speed), 2);

    // Simultaneous next/prev/pause at index 5.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    next_pls = 1'b1;
    repeat (5) @(negedge clk);
    next_pls = 1'b0;
    check_eq("five_next_ani", int'(animation), 5);
    count_blank(bc);
    check_eq("blank_end_a", int'(blank), 0);
    next_pls = 1'b1; prev_pls = 1'b1; pause_pls = 1'b1;
    @(negedge clk);
    next_pls = 1'b0; prev_pls = 1'b0; pause_pls = 1'b0;
    check_eq("combo_ani", int'(animation), 6);
    check_eq("combo_paused", int'(paused), 0);
    check_eq("combo_blank", int'(blank), 1);
    pause_pls = 1'b1;
    @(negedge clk);
    pause_pls = 1'b0;
    check_eq("pause_in_blank_ignored", int'(paused), 0);
    count_blank(bc);
    check_eq("blank_len_combo", bc, 2);
    check_eq("play_after_blank", int'(paused), 0);

    // Pause mid-frame holds count; resume completes the remainder.
    wait_tick(20, n);
    check_eq("tick_after_blank2", n, 8);
    check_eq("frame_before_pause", int'(frame), 1);
    repeat (2) @(negedge clk);
    pause_pls = 1'b1;
    @(negedge clk);
    pause_pls = 1'b0;
    check_eq("paused_set", int'(paused), 1);
    ticks_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (frame_tick) ticks_seen++;
    end
    check_eq("pause_no_ticks", ticks_seen, 0);
    check_eq("pause_frame_hold", int'(frame), 1);
    pause_pls = 1'b1;
    @(negedge clk);
    pause_pls = 1'b0;
    check_eq("resumed", int'(paused), 0);
    wait_tick(20, n);
    check_eq("resume_remainder", n, 5);
    check_eq("frame_after_resume", int'(frame), 2);

    // Reset during BLANK returns everything to reset values.
    slower_pls = 1'b1;
    @(negedge clk);
    slower_pls = 1'b0;
    check_eq("speed_up_one", int'(speed), 3);
    next_pls = 1'b1;
    @(negedge clk);
    next_pls = 1'b0;
    check_eq("blank_before_rst", int'(blank), 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_blank");
    reset = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
